// File: rtl/pp_pkg.sv
// Shared preprocessing package: default frame geometry, derived widths,
// tracker FSM state type and the bounding-box result word.
package pp_pkg;

  localparam int PP_WIDTH  = 640;
  localparam int PP_HEIGHT = 480;

  localparam int PP_XW = $clog2(PP_WIDTH);
  localparam int PP_YW = $clog2(PP_HEIGHT);
  localparam int PP_CW = $clog2(PP_WIDTH * PP_HEIGHT + 1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } tracker_state_t;

  // Result word sized for the default geometry; smaller frames use the
  // low bits of each field with the upper bits held at zero.
  typedef struct packed {
    logic             found;
    logic [PP_XW-1:0] xmin;
    logic [PP_XW-1:0] xmax;
    logic [PP_YW-1:0] ymin;
    logic [PP_YW-1:0] ymax;
    logic [PP_CW-1:0] count;
  } bbox_t;

endpackage

// File: rtl/red_mask_bbox_tracker_if.sv
// Mask-stream input and bounding-box result handshake for red_mask_bbox_tracker.
// slave  : tracker side (consumes the mask stream, drives the result).
// master : source/sink side (drives the mask stream, accepts the result).
interface red_mask_bbox_tracker_if
  import pp_pkg::*;
#(
  parameter int WIDTH  = PP_WIDTH,
  parameter int HEIGHT = PP_HEIGHT
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH * HEIGHT + 1);

  logic          i_sof;
  logic          i_valid;
  logic          i_pixel_is_red;
  logic          i_ready;
  logic          o_valid;
  logic          o_found;
  logic [XW-1:0] o_xmin;
  logic [XW-1:0] o_xmax;
  logic [YW-1:0] o_ymin;
  logic [YW-1:0] o_ymax;
  logic [CW-1:0] o_count;
  logic          o_sync_err;

  modport slave (
    input  i_sof, i_valid, i_pixel_is_red, i_ready,
    output o_valid, o_found, o_xmin, o_xmax, o_ymin, o_ymax, o_count, o_sync_err
  );

  modport master (
    output i_sof, i_valid, i_pixel_is_red, i_ready,
    input  o_valid, o_found, o_xmin, o_xmax, o_ymin, o_ymax, o_count, o_sync_err
  );

endinterface

// File: rtl/red_mask_bbox_tracker_raster_counter.sv
// raster_counter: x/y position of the sample currently presented.
// A start-of-frame sample is always position (0,0); the stored position
// advances only on accepted samples and wraps to (0,0) after the last pixel.
module raster_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_adv,
  input  logic          i_sof,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last_pixel,
  output logic          o_at_origin
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_eol;
  logic          w_eof;

  assign o_x          = i_sof ? '0 : r_x;
  assign o_y          = i_sof ? '0 : r_y;
  assign w_eol        = (o_x == XW'(WIDTH - 1));
  assign w_eof        = (o_y == YW'(HEIGHT - 1));
  assign o_last_pixel = w_eol && w_eof;
  assign o_at_origin  = (r_x == '0) && (r_y == '0);

  // Step to the position of the next sample in raster order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= w_eof ? '0 : o_y + YW'(1);
      end else begin
        r_x <= o_x + XW'(1);
        r_y <= o_y;
      end
    end
  end

endmodule

// File: rtl/red_mask_bbox_tracker.sv
// red_mask_bbox_tracker: accumulates the bounding box and hit count of the
// red-mask pixels in each frame and publishes one result word per frame.
// Optional build macro RED_BBOX_MIN_COUNT_EN: found requires at least
// MIN_PIXELS hits; otherwise any hit sets found.
module red_mask_bbox_tracker
  import pp_pkg::*;
#(
  parameter int WIDTH      = PP_WIDTH,
  parameter int HEIGHT     = PP_HEIGHT,
  parameter int MIN_PIXELS = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  red_mask_bbox_tracker_if.slave   bus
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH * HEIGHT + 1);

`ifdef RED_BBOX_MIN_COUNT_EN
  localparam logic [CW-1:0] FOUND_THR = CW'(MIN_PIXELS);
`else
  // A single hit qualifies; MIN_PIXELS has no effect in this build.
  localparam logic [CW-1:0] FOUND_THR = CW'(MIN_PIXELS * 0 + 1);
`endif

  tracker_state_t r_state;
  logic [XW-1:0]  r_xmin, r_xmax;
  logic [YW-1:0]  r_ymin, r_ymax;
  logic [CW-1:0]  r_count;
  bbox_t          r_out;
  logic           r_out_valid;
  logic           r_sync_err;

  logic           w_start;
  logic           w_acc;
  logic           w_red;
  logic [XW-1:0]  w_x;
  logic [YW-1:0]  w_y;
  logic           w_last;
  logic           w_at_origin;
  logic [XW-1:0]  w_base_xmin, w_base_xmax, w_nxt_xmin, w_nxt_xmax;
  logic [YW-1:0]  w_base_ymin, w_base_ymax, w_nxt_ymin, w_nxt_ymax;
  logic [CW-1:0]  w_base_count, w_nxt_count;
  logic           w_found;

  // A start-of-frame sample is accepted in any state; others only mid-frame.
  assign w_start = bus.i_valid && bus.i_sof;
  assign w_acc   = bus.i_valid && (bus.i_sof || (r_state == ACCUM));
  assign w_red   = w_acc && bus.i_pixel_is_red;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_raster (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_adv        (w_acc),
    .i_sof        (w_start),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_last_pixel (w_last),
    .o_at_origin  (w_at_origin)
  );

  // Frame start folds the current pixel into freshly initialised accumulators.
  assign w_base_xmin  = w_start ? XW'(WIDTH - 1)  : r_xmin;
  assign w_base_xmax  = w_start ? '0              : r_xmax;
  assign w_base_ymin  = w_start ? YW'(HEIGHT - 1) : r_ymin;
  assign w_base_ymax  = w_start ? '0              : r_ymax;
  assign w_base_count = w_start ? '0              : r_count;

  assign w_nxt_xmin  = (w_red && (w_x < w_base_xmin)) ? w_x : w_base_xmin;
  assign w_nxt_xmax  = (w_red && (w_x > w_base_xmax)) ? w_x : w_base_xmax;
  assign w_nxt_ymin  = (w_red && (w_y < w_base_ymin)) ? w_y : w_base_ymin;
  assign w_nxt_ymax  = (w_red && (w_y > w_base_ymax)) ? w_y : w_base_ymax;
  assign w_nxt_count = w_base_count + CW'(w_red);
  assign w_found     = (w_nxt_count >= FOUND_THR);

  // Frame FSM, accumulators, resync pulse and the result register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= WAIT_SOF;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymin      <= '0;
      r_ymax      <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_sync_err <= (r_state == ACCUM) && w_start && !w_at_origin;

      if (r_out_valid && bus.i_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_acc) begin
        r_xmin  <= w_nxt_xmin;
        r_xmax  <= w_nxt_xmax;
        r_ymin  <= w_nxt_ymin;
        r_ymax  <= w_nxt_ymax;
        r_count <= w_nxt_count;
        if (w_last) begin
          // Newest frame wins even if the previous result is still pending.
          r_out <= '{found: w_found,
                     xmin:  PP_XW'(w_nxt_xmin),
                     xmax:  PP_XW'(w_nxt_xmax),
                     ymin:  PP_YW'(w_nxt_ymin),
                     ymax:  PP_YW'(w_nxt_ymax),
                     count: PP_CW'(w_nxt_count)};
          r_out_valid <= 1'b1;
          r_state     <= WAIT_SOF;
        end else begin
          r_state <= ACCUM;
        end
      end
    end
  end

  assign bus.o_valid    = r_out_valid;
  assign bus.o_found    = r_out.found;
  assign bus.o_xmin     = XW'(r_out.xmin);
  assign bus.o_xmax     = XW'(r_out.xmax);
  assign bus.o_ymin     = YW'(r_out.ymin);
  assign bus.o_ymax     = YW'(r_out.ymax);
  assign bus.o_count    = CW'(r_out.count);
  assign bus.o_sync_err = r_sync_err;

endmodule

// File: tb/tb_red_mask_bbox_tracker.sv
// Directed bench for red_mask_bbox_tracker on an 8x4 frame.
// Mask bit index is y*8 + x.
module tb_red_mask_bbox_tracker;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  red_mask_bbox_tracker_if #(.WIDTH(8), .HEIGHT(4)) bus ();

  red_mask_bbox_tracker #(
    .WIDTH      (8),
    .HEIGHT     (4),
    .MIN_PIXELS (16)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {found, xmin, xmax, ymin, ymax, count} = 1+3+3+2+2+6 bits
  logic [16:0] res;
  assign res = {bus.o_found, bus.o_xmin, bus.o_xmax, bus.o_ymin, bus.o_ymax, bus.o_count};

  localparam logic [31:0] MASK_A = 32'h2000_0400;  // (2,1) and (5,3)
  localparam logic [31:0] MASK_B = 32'h8000_0001;  // (0,0) and (7,3)
  localparam logic [31:0] MASK_C = 32'h0010_4000;  // (6,1) and (4,2)
  localparam logic [31:0] MASK_P = 32'h0000_0180;  // (7,0) and (0,1)

  localparam logic [16:0] EXP_A    = {1'b1, 3'd2, 3'd5, 2'd1, 2'd3, 6'd2};
  localparam logic [16:0] EXP_B    = {1'b1, 3'd0, 3'd7, 2'd0, 2'd3, 6'd2};
  localparam logic [16:0] EXP_C    = {1'b1, 3'd4, 3'd6, 2'd1, 2'd2, 6'd2};
  localparam logic [16:0] EXP_ZERO = {1'b0, 3'd7, 3'd0, 2'd3, 2'd0, 6'd0};
`ifdef RED_BBOX_MIN_COUNT_EN
  localparam logic FOUND_15 = 1'b0;
`else
  localparam logic FOUND_15 = 1'b1;
`endif
  localparam logic [16:0] EXP_15 = {FOUND_15, 3'd0, 3'd7, 2'd0, 2'd1, 6'd15};
  localparam logic [16:0] EXP_16 = {1'b1,     3'd0, 3'd7, 2'd0, 2'd1, 6'd16};

  task automatic send(input logic sof, input logic red);
    bus.i_sof          = sof;
    bus.i_valid        = 1'b1;
    bus.i_pixel_is_red = red;
    @(posedge clk);
    #1;
    bus.i_sof          = 1'b0;
    bus.i_valid        = 1'b0;
    bus.i_pixel_is_red = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [31:0] m, input int gap_pct);
    for (int i = 0; i < 32; i++) begin
      if (gap_pct > 0) begin
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 99) < gap_pct) idle(1);
        end
      end
      send(i == 0, m[i]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.i_sof = 1'b0; bus.i_valid = 1'b0; bus.i_pixel_is_red = 1'b0; bus.i_ready = 1'b1;
    #23;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
    n_checks++;
    if (bus.o_sync_err !== 1'b0) begin n_errors++; $display("FAIL reset_sync_err got %b exp 0", bus.o_sync_err); end
    n_checks++;
    if (res !== 17'h0) begin n_errors++; $display("FAIL reset_result got %h exp %h", res, 17'h0); end
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    bus.i_ready = 1'b1;
    // Red samples before any start-of-frame must be ignored.
    send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL pre_sof_valid got %b exp 0", bus.o_valid); end
    drive_frame(MASK_A, 0);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid got %b exp 1", bus.o_valid); end
    n_checks++;
    if (res !== EXP_A) begin n_errors++; $display("FAIL basic_result got %h exp %h", res, EXP_A); end
    idle(1);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL basic_valid_drop got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_all_zero();
    drive_frame(32'h0, 0);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL zero_valid got %b exp 1", bus.o_valid); end
    n_checks++;
    if (res !== EXP_ZERO) begin n_errors++; $display("FAIL zero_result got %h exp %h", res, EXP_ZERO); end
    idle(1);
  endtask

  task automatic test_gaps();
    drive_frame(MASK_A, 30);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL gaps_valid got %b exp 1", bus.o_valid); end
    n_checks++;
    if (res !== EXP_A) begin n_errors++; $display("FAIL gaps_result got %h exp %h", res, EXP_A); end
    idle(1);
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    drive_frame(MASK_A, 0);
    idle(3);
    n_checks++;
    if (bus.o_valid !== 1'b1 || res !== EXP_A) begin
      n_errors++; $display("FAIL bp_hold got valid %b result %h exp valid 1 result %h", bus.o_valid, res, EXP_A);
    end
    drive_frame(MASK_B, 0);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid got %b exp 1", bus.o_valid); end
    n_checks++;
    if (res !== EXP_B) begin n_errors++; $display("FAIL bp_newest got %h exp %h", res, EXP_B); end
    bus.i_ready = 1'b1;
    idle(1);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drop got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_sync_err();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 19; i++) send(i == 0, MASK_P[i]);
    n_checks++;
    if (bus.o_sync_err !== 1'b0) begin n_errors++; $display("FAIL sync_quiet got %b exp 0", bus.o_sync_err); end
    // Start-of-frame arrives at (3,2).
    send(1'b1, MASK_C[0]);
    n_checks++;
    if (bus.o_sync_err !== 1'b1) begin n_errors++; $display("FAIL sync_pulse got %b exp 1", bus.o_sync_err); end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL sync_no_result got %b exp 0", bus.o_valid); end
    for (int i = 1; i < 32; i++) begin
      send(1'b0, MASK_C[i]);
      if (i == 1) begin
        n_checks++;
        if (bus.o_sync_err !== 1'b0) begin n_errors++; $display("FAIL sync_one_cycle got %b exp 0", bus.o_sync_err); end
      end
    end
    n_checks++;
    if (bus.o_valid !== 1'b1 || res !== EXP_C) begin
      n_errors++; $display("FAIL sync_next_frame got valid %b result %h exp valid 1 result %h", bus.o_valid, res, EXP_C);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 10; i++) send(i == 0, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.o_count !== 6'd0 || bus.o_valid !== 1'b0) begin
      n_errors++; $display("FAIL midreset_clear got count %0d valid %b exp count 0 valid 0", bus.o_count, bus.o_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    // Leftover samples of the interrupted frame carry no start-of-frame.
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_dropped got %b exp 0", bus.o_valid); end
    drive_frame(MASK_A, 0);
    n_checks++;
    if (bus.o_valid !== 1'b1 || res !== EXP_A) begin
      n_errors++; $display("FAIL midreset_frame got valid %b result %h exp valid 1 result %h", bus.o_valid, res, EXP_A);
    end
    idle(1);
  endtask

  task automatic test_min_count();
    drive_frame(32'h0000_7FFF, 0);
    n_checks++;
    if (res !== EXP_15) begin n_errors++; $display("FAIL min15_result got %h exp %h", res, EXP_15); end
    idle(1);
    drive_frame(32'h0000_FFFF, 0);
    n_checks++;
    if (res !== EXP_16) begin n_errors++; $display("FAIL min16_result got %h exp %h", res, EXP_16); end
    idle(1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_all_zero();
    test_gaps();
    test_backpressure();
    test_sync_err();
    test_reset_mid_frame();
    test_min_count();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
